axi4_lite_master: RTL

- AXI4-Lite initiator (master) that turns single-word commands from a local requester (CPU core or bus bridge) into AXI4-Lite write or read transactions.
- Drives the same AW/W/B/AR/R channel set that the GPIO/peripheral slaves respond to.
- One outstanding transaction at a time.
- Returns read data and response code to the requester as a one-cycle response pulse.

---
 rtl/axi4_lite_master.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator: one outstanding single-word read or write per requester command.
// Optional watchdog enabled by defining AXI_MASTER_TIMEOUT_EN (aborts a stalled transfer with SLVERR).
module axi4_lite_master #(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              busy,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RVALID,
  output logic              RREADY
);

  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WB,
    S_RA,
    S_RR,
    S_DONE
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              aw_done_reg;
  logic              w_done_reg;
  logic              awvalid_reg;
  logic              wvalid_reg;
  logic              bready_reg;
  logic              arvalid_reg;
  logic              rready_reg;
  logic              cmd_ready_reg;
  logic              busy_reg;
  logic              rsp_valid_reg;
  logic [DATA_W-1:0] rsp_rdata_reg;
  logic [1:0]        rsp_resp_reg;

  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic aw_ok;
  logic w_ok;
  logic active;
  logic step_done;
  logic timeout;

  assign aw_hs  = awvalid_reg & AWREADY;
  assign w_hs   = wvalid_reg & WREADY;
  assign ar_hs  = arvalid_reg & ARREADY;
  assign aw_ok  = aw_done_reg | aw_hs;
  assign w_ok   = w_done_reg | w_hs;
  assign active = (state_reg == S_WR) || (state_reg == S_WB) ||
                  (state_reg == S_RA) || (state_reg == S_RR);

  // Any edge on which the FSM leaves its current bus-phase state.
  assign step_done = ((state_reg == S_WR) && aw_ok && w_ok) ||
                     ((state_reg == S_WB) && BVALID) ||
                     ((state_reg == S_RA) && ar_hs) ||
                     ((state_reg == S_RR) && RVALID);

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] timer_reg;

  // Counts cycles spent in the current bus-phase state; restarts on every state change.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      timer_reg <= '0;
    end else if (!active || step_done || timeout) begin
      timer_reg <= '0;
    end else if (timer_reg != TMR_W'(TIMEOUT_CYCLES)) begin
      timer_reg <= timer_reg + 1'b1;
    end
  end

  assign timeout = active && (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog absent: the limit is kept only so both builds share one parameter list.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout = 1'b0;
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_reg     <= S_IDLE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      bready_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      rready_reg    <= 1'b0;
      cmd_ready_reg <= 1'b1;
      busy_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_resp_reg  <= 2'b00;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_reg      <= cmd_addr;
            wdata_reg     <= cmd_wdata;
            aw_done_reg   <= 1'b0;
            w_done_reg    <= 1'b0;
            cmd_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            if (cmd_write) begin
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
              state_reg   <= S_WR;
            end else begin
              arvalid_reg <= 1'b1;
              state_reg   <= S_RA;
            end
          end
        end
        S_WR: begin
          if (timeout) begin
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_resp_reg  <= RESP_SLVERR;
            rsp_valid_reg <= 1'b1;
            state_reg     <= S_DONE;
          end else begin
            if (aw_hs) begin
              awvalid_reg <= 1'b0;
              aw_done_reg <= 1'b1;
            end
            if (w_hs) begin
              wvalid_reg <= 1'b0;
              w_done_reg <= 1'b1;
            end
            if (aw_ok && w_ok) begin
              bready_reg <= 1'b1;
              state_reg  <= S_WB;
            end
          end
        end
        S_WB: begin
          if (timeout || BVALID) begin
            bready_reg    <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_resp_reg  <= timeout ? RESP_SLVERR : BRESP;
            rsp_valid_reg <= 1'b1;
            state_reg     <= S_DONE;
          end
        end
        S_RA: begin
          if (timeout) begin
            arvalid_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_resp_reg  <= RESP_SLVERR;
            rsp_valid_reg <= 1'b1;
            state_reg     <= S_DONE;
          end else if (ar_hs) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            state_reg   <= S_RR;
          end
        end
        S_RR: begin
          if (timeout || RVALID) begin
            rready_reg    <= 1'b0;
            rsp_rdata_reg <= timeout ? '0 : RDATA;
            rsp_resp_reg  <= timeout ? RESP_SLVERR : RRESP;
            rsp_valid_reg <= 1'b1;
            state_reg     <= S_DONE;
          end
        end
        S_DONE: begin
          busy_reg      <= 1'b0;
          cmd_ready_reg <= 1'b1;
          state_reg     <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_reg;
  assign busy      = busy_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_resp  = rsp_resp_reg;
  assign AWADDR    = addr_reg;
  assign ARADDR    = addr_reg;
  assign WDATA     = wdata_reg;
  assign AWVALID   = awvalid_reg;
  assign WVALID    = wvalid_reg;
  assign BREADY    = bready_reg;
  assign ARVALID   = arvalid_reg;
  assign RREADY    = rready_reg;

endmodule
